// File: rtl/ajuste_relogio.sv
// -----------------------------------------------------------------------------
// ajuste_relogio : time-entry front end for the BCD clock.
//
// Writes the clock's hh:mm registers. Two raw push-buttons (mode, increment)
// are synchronized and debounced into one-cycle pulses that drive a small
// edit state machine:
//   RUN    -> mode captures the running time and starts editing the hours
//   SET_H  -> inc steps the hour pair (23 wraps to 00), mode moves on
//   SET_M  -> inc steps the minute pair (59 wraps to 00), mode commits
//   COMMIT -> one-cycle load strobe, then back to RUN
// While editing, the counters are paused and the field being edited blinks
// at the 1 Hz tick rate. An edit left idle for TIMEOUT_S ticks is abandoned
// without loading anything.
//
// Ports
//   main_clock             system clock
//   main_reset             asynchronous, active-low reset
//   enable_1hz             one-cycle pulse per second
//   btn_mode, btn_inc      raw, bouncy, active-high buttons
//   cur_h_msd..cur_m_lsd   current time from the counters (BCD)
//   set_h_msd..set_m_lsd   edited time to load (BCD, always legal)
//   load                   one-cycle strobe: counters take set_*, seconds 00
//   pause                  high while editing, counters ignore enable_1hz
//   blank_h, blank_m       blank the hour / minute digit pair (blink)
// -----------------------------------------------------------------------------

// Per-button conditioner: 2-FF synchronizer, stability counter, and a
// one-cycle pulse on each accepted rising level.
module ajuste_relogio_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic main_clock,
  input  logic main_reset,
  input  logic raw,
  output logic rise
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          level;
  logic [CW-1:0] stable_cnt;
  logic          changing;
  logic          settled;

  // sync_a differing from sync_b means the synchronized level is about to
  // change, so the stability count restarts one cycle early; this keeps the
  // press-to-pulse latency at 2 + DEBOUNCE_CYCLES.
  assign changing = (sync_a != sync_b);
  assign settled  = !changing && (stable_cnt == CNT_MAX);

  // The pulse is taken in the same cycle the debounced level is updated, so
  // a held button produces exactly one pulse.
  assign rise = settled && sync_b && !level;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  always_ff @(posedge main_clock or negedge main_reset) begin
    if (!main_reset) begin
      sync_a     <= 1'b0;
      sync_b     <= 1'b0;
      level      <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      if (changing) begin
        stable_cnt <= '0;
      end else if (stable_cnt != CNT_MAX) begin
        stable_cnt <= stable_cnt + CW'(1);
      end
      if (settled) begin
        level <= sync_b;
      end
    end
  end

endmodule

module ajuste_relogio #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMEOUT_S       = 30
) (
  input  logic       main_clock,
  input  logic       main_reset,
  input  logic       enable_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [2:0] cur_h_msd,
  input  logic [3:0] cur_h_lsd,
  input  logic [2:0] cur_m_msd,
  input  logic [3:0] cur_m_lsd,
  output logic [2:0] set_h_msd,
  output logic [3:0] set_h_lsd,
  output logic [2:0] set_m_msd,
  output logic [3:0] set_m_lsd,
  output logic       load,
  output logic       pause,
  output logic       blank_h,
  output logic       blank_m
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_H  = 2'd1,
    SET_M  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam int unsigned IW = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S + 1) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_S - 1);

  state_t        state;
  logic          blink;
  logic [IW-1:0] idle;

  logic          p_mode;
  logic          p_inc;

  // ---------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------
  ajuste_relogio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
    .main_clock (main_clock),
    .main_reset (main_reset),
    .raw        (btn_mode),
    .rise       (p_mode)
  );

  ajuste_relogio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
    .main_clock (main_clock),
    .main_reset (main_reset),
    .raw        (btn_inc),
    .rise       (p_inc)
  );

  // ---------------------------------------------------------------------------
  // Datapath helpers: captured (clamped) time, incremented fields, next blink
  // ---------------------------------------------------------------------------
  logic       hour_ok;
  logic       min_ok;
  logic [2:0] cap_h_msd;
  logic [3:0] cap_h_lsd;
  logic [2:0] cap_m_msd;
  logic [3:0] cap_m_lsd;
  logic [2:0] nxt_h_msd;
  logic [3:0] nxt_h_lsd;
  logic [2:0] nxt_m_msd;
  logic [3:0] nxt_m_lsd;
  logic       blink_nxt;

  // Illegal captured fields are forced to 00 so the edit registers only ever
  // hold values the counters can represent.
  assign hour_ok = (cur_h_msd <= 3'd2) && (cur_h_lsd <= 4'd9) &&
                   !((cur_h_msd == 3'd2) && (cur_h_lsd > 4'd3));
  assign min_ok  = (cur_m_msd <= 3'd5) && (cur_m_lsd <= 4'd9);

  // An increment press always makes the field visible again; otherwise the
  // blink phase follows the 1 Hz tick.
  assign blink_nxt = p_inc ? 1'b0 : (enable_1hz ? !blink : blink);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    cap_h_msd = 3'd0;
    cap_h_lsd = 4'd0;
    cap_m_msd = 3'd0;
    cap_m_lsd = 4'd0;
    if (hour_ok) begin
      cap_h_msd = cur_h_msd;
      cap_h_lsd = cur_h_lsd;
    end
    if (min_ok) begin
      cap_m_msd = cur_m_msd;
      cap_m_lsd = cur_m_lsd;
    end

    // Hour pair: 09 -> 10, 19 -> 20, 23 -> 00.
    nxt_h_msd = set_h_msd;
    nxt_h_lsd = set_h_lsd + 4'd1;
    if ((set_h_msd == 3'd2) && (set_h_lsd == 4'd3)) begin
      nxt_h_msd = 3'd0;
      nxt_h_lsd = 4'd0;
    end else if (set_h_lsd == 4'd9) begin
      nxt_h_msd = set_h_msd + 3'd1;
      nxt_h_lsd = 4'd0;
    end

    // Minute pair: x9 -> (x+1)0, 59 -> 00, never carries into the hour.
    nxt_m_msd = set_m_msd;
    nxt_m_lsd = set_m_lsd + 4'd1;
    if (set_m_lsd == 4'd9) begin
      nxt_m_lsd = 4'd0;
      nxt_m_msd = (set_m_msd == 3'd5) ? 3'd0 : set_m_msd + 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Edit state machine with registered outputs.
  // Priority inside an edit state: mode pulse, then inc pulse, then the 1 Hz
  // tick. A mode pulse therefore swallows a simultaneous inc, and any pulse
  // cancels a timeout falling in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge main_clock or negedge main_reset) begin
    if (!main_reset) begin
      state     <= RUN;
      blink     <= 1'b0;
      idle      <= '0;
      set_h_msd <= 3'd0;
      set_h_lsd <= 4'd0;
      set_m_msd <= 3'd0;
      set_m_lsd <= 4'd0;
      load      <= 1'b0;
      pause     <= 1'b0;
      blank_h   <= 1'b0;
      blank_m   <= 1'b0;
    end else begin
      load <= 1'b0;

      case (state)
        RUN: begin
          pause   <= 1'b0;
          blank_h <= 1'b0;
          blank_m <= 1'b0;
          if (p_mode) begin
            set_h_msd <= cap_h_msd;
            set_h_lsd <= cap_h_lsd;
            set_m_msd <= cap_m_msd;
            set_m_lsd <= cap_m_lsd;
            state     <= SET_H;
            pause     <= 1'b1;
            blink     <= 1'b0;
            idle      <= '0;
          end
        end

        SET_H: begin
          if (p_mode) begin
            state   <= SET_M;
            idle    <= '0;
            blink   <= blink_nxt;
            blank_h <= 1'b0;
            blank_m <= blink_nxt;
          end else if (p_inc) begin
            set_h_msd <= nxt_h_msd;
            set_h_lsd <= nxt_h_lsd;
            idle      <= '0;
            blink     <= 1'b0;
            blank_h   <= 1'b0;
          end else if (enable_1hz) begin
            if (idle == IDLE_LAST) begin
              state   <= RUN;
              pause   <= 1'b0;
              blink   <= 1'b0;
              blank_h <= 1'b0;
              idle    <= '0;
            end else begin
              idle    <= idle + IW'(1);
              blink   <= !blink;
              blank_h <= !blink;
            end
          end
        end

        SET_M: begin
          if (p_mode) begin
            state   <= COMMIT;
            load    <= 1'b1;
            idle    <= '0;
            blink   <= 1'b0;
            blank_m <= 1'b0;
          end else if (p_inc) begin
            set_m_msd <= nxt_m_msd;
            set_m_lsd <= nxt_m_lsd;
            idle      <= '0;
            blink     <= 1'b0;
            blank_m   <= 1'b0;
          end else if (enable_1hz) begin
            if (idle == IDLE_LAST) begin
              state   <= RUN;
              pause   <= 1'b0;
              blink   <= 1'b0;
              blank_m <= 1'b0;
              idle    <= '0;
            end else begin
              idle    <= idle + IW'(1);
              blink   <= !blink;
              blank_m <= !blink;
            end
          end
        end

        COMMIT: begin
          // load was raised on entry and is dropped by the default above.
          state <= RUN;
          pause <= 1'b0;
        end

        default: begin
          state   <= RUN;
          pause   <= 1'b0;
          blink   <= 1'b0;
          blank_h <= 1'b0;
          blank_m <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ajuste_relogio.sv
// -----------------------------------------------------------------------------
// tb_ajuste_relogio : self-checking bench for ajuste_relogio.
//
// A reference model tracks the edited time as plain integers (hour 0..23,
// minute 0..59) and an edit phase. Each stimulus action updates the model and
// queues the output snapshot it expects next. A monitor compares every change
// of the DUT outputs against the head of that queue.
// -----------------------------------------------------------------------------
module tb_ajuste_relogio;

  localparam int DEB = 4;
  localparam int TMO = 3;

  logic       main_clock = 1'b0;
  logic       main_reset = 1'b0;
  logic       enable_1hz = 1'b0;
  logic       btn_mode   = 1'b0;
  logic       btn_inc    = 1'b0;
  logic [2:0] cur_h_msd  = 3'd1;
  logic [3:0] cur_h_lsd  = 4'd2;
  logic [2:0] cur_m_msd  = 3'd3;
  logic [3:0] cur_m_lsd  = 4'd4;
  logic [2:0] set_h_msd;
  logic [3:0] set_h_lsd;
  logic [2:0] set_m_msd;
  logic [3:0] set_m_lsd;
  logic       load;
  logic       pause;
  logic       blank_h;
  logic       blank_m;

  ajuste_relogio #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_S(TMO)) dut (
    .main_clock (main_clock),
    .main_reset (main_reset),
    .enable_1hz (enable_1hz),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .cur_h_msd  (cur_h_msd),
    .cur_h_lsd  (cur_h_lsd),
    .cur_m_msd  (cur_m_msd),
    .cur_m_lsd  (cur_m_lsd),
    .set_h_msd  (set_h_msd),
    .set_h_lsd  (set_h_lsd),
    .set_m_msd  (set_m_msd),
    .set_m_lsd  (set_m_lsd),
    .load       (load),
    .pause      (pause),
    .blank_h    (blank_h),
    .blank_m    (blank_m)
  );

  always #5 main_clock = ~main_clock;

  typedef struct packed {
    logic [2:0] h_msd;
    logic [3:0] h_lsd;
    logic [2:0] m_msd;
    logic [3:0] m_lsd;
    logic       load;
    logic       pause;
    logic       blank_h;
    logic       blank_m;
  } snap_t;

  snap_t exp_q[$];
  snap_t m_last   = '0;
  snap_t mon_prev = '0;
  snap_t now_s;
  bit    mon_en   = 1'b0;

  int total       = 0;
  int bad         = 0;
  int load_cycles = 0;

  // Reference model state
  int m_phase = 0;  // 0 running, 1 editing hours, 2 editing minutes
  int m_h     = 0;
  int m_m     = 0;
  bit m_blink = 1'b0;
  int m_idle  = 0;
  int m_loads = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    total++;
    if (val < lo || val > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  function automatic snap_t dut_view();
    snap_t s;
    s.h_msd   = set_h_msd;
    s.h_lsd   = set_h_lsd;
    s.m_msd   = set_m_msd;
    s.m_lsd   = set_m_lsd;
    s.load    = load;
    s.pause   = pause;
    s.blank_h = blank_h;
    s.blank_m = blank_m;
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic snap_t model_view(input bit ld);
    snap_t s;
    s.h_msd   = 3'(m_h / 10);
    s.h_lsd   = 4'(m_h % 10);
    s.m_msd   = 3'(m_m / 10);
    s.m_lsd   = 4'(m_m % 10);
    s.load    = ld;
    s.pause   = ld || (m_phase != 0);
    s.blank_h = (m_phase == 1) && m_blink;
    s.blank_m = (m_phase == 2) && m_blink;
    return s;
  endfunction

  function automatic void model_emit();
    snap_t s;
    s = model_view(1'b0);
    if (s != m_last) begin
      exp_q.push_back(s);
      m_last = s;
    end
  endfunction

  function automatic void model_reset();
    m_phase = 0;
    m_h     = 0;
    m_m     = 0;
    m_blink = 1'b0;
    m_idle  = 0;
    model_emit();
  endfunction

  function automatic void model_capture();
    int h;
    int m;
    h = int'(cur_h_msd) * 10 + int'(cur_h_lsd);
    m = int'(cur_m_msd) * 10 + int'(cur_m_lsd);
    m_h = (cur_h_msd <= 2 && cur_h_lsd <= 9 && h <= 23) ? h : 0;
    m_m = (cur_m_msd <= 5 && cur_m_lsd <= 9) ? m : 0;
  endfunction

  function automatic void model_pulse(input bit mode, input bit inc);
    snap_t s;
    if (inc && m_phase != 0) m_blink = 1'b0;
    if (mode) begin
      m_idle = 0;
      if (m_phase == 0) begin
        model_capture();
        m_phase = 1;
        m_blink = 1'b0;
        model_emit();
      end else if (m_phase == 1) begin
        m_phase = 2;
        model_emit();
      end else begin
        m_phase = 0;
        m_blink = 1'b0;
        s = model_view(1'b1);
        exp_q.push_back(s);
        m_last = s;
        m_loads++;
        model_emit();
      end
    end else if (inc && m_phase != 0) begin
      m_idle = 0;
      if (m_phase == 1) m_h = (m_h + 1) % 24;
      else              m_m = (m_m + 1) % 60;
      model_emit();
    end
  endfunction

  function automatic void model_tick();
    if (m_phase != 0) begin
      if (m_idle + 1 >= TMO) begin
        m_phase = 0;
        m_blink = 1'b0;
        m_idle  = 0;
      end else begin
        m_idle++;
        m_blink = !m_blink;
      end
      model_emit();
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: every change of the outputs must match the next expected snapshot
  // ---------------------------------------------------------------------------
  always @(negedge main_clock) begin
    if (mon_en) begin
      now_s = dut_view();
      if (now_s !== mon_prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_change: got %0h expected no change from %0h", now_s, mon_prev);
        end else begin
          check("output_step", now_s, exp_q.pop_front());
        end
        mon_prev = now_s;
      end
    end
  end

  always @(negedge main_clock) begin
    if (load === 1'b1) load_cycles++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic set_cur(input int hm, input int hl, input int mm, input int ml);
    cur_h_msd = 3'(hm);
    cur_h_lsd = 4'(hl);
    cur_m_msd = 3'(mm);
    cur_m_lsd = 4'(ml);
  endtask

  task automatic press(input bit mode, input bit inc);
    @(negedge main_clock);
    btn_mode = mode;
    btn_inc  = inc;
    model_pulse(mode, inc);
    repeat (8) @(negedge main_clock);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (10) @(negedge main_clock);
  endtask

  task automatic tick();
    @(negedge main_clock);
    enable_1hz = 1'b1;
    model_tick();
    @(negedge main_clock);
    enable_1hz = 1'b0;
    repeat (3) @(negedge main_clock);
  endtask

  int lat;
  int lc0;
  int r;

  initial begin
    // Reset with 12:34 on the inputs
    set_cur(1, 2, 3, 4);
    model_reset();
    repeat (3) @(negedge main_clock);
    check("reset_outputs", dut_view(), model_view(1'b0));
    main_reset = 1'b1;
    mon_prev   = dut_view();
    mon_en     = 1'b1;
    repeat (3) @(negedge main_clock);

    // Clean mode press: pause rises after about 2 + DEB cycles
    @(negedge main_clock);
    btn_mode = 1'b1;
    model_pulse(1'b1, 1'b0);
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge main_clock);
      #1;
      if (pause === 1'b1 && lat == 0) lat = i;
    end
    check_range("mode_press_latency", lat, 2 + DEB - 1, 2 + DEB + 1);
    @(negedge main_clock);
    btn_mode = 1'b0;
    repeat (10) @(negedge main_clock);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);  // commit 12:34

    // Hour wrap 22 -> 23 -> 00, minute 00 -> 01, commit 00:01
    set_cur(2, 2, 0, 0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("hour_23", {set_h_msd, set_h_lsd}, {3'd2, 4'd3});
    press(1'b0, 1'b1);
    check("hour_wrap_00", {set_h_msd, set_h_lsd, set_m_msd, set_m_lsd}, 14'd0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    check("after_commit_pause", pause, 1'b0);

    // Minute wrap 59 -> 00 with the hour kept, then 09 -> 10
    set_cur(0, 7, 5, 9);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("minute_wrap", {set_h_msd, set_h_lsd, set_m_msd, set_m_lsd}, {3'd0, 4'd7, 3'd0, 4'd0});
    repeat (10) press(1'b0, 1'b1);
    check("minute_09_to_10", {set_m_msd, set_m_lsd}, {3'd1, 4'd0});
    press(1'b1, 1'b0);

    // Bouncy press, long hold, then a short glitch
    set_cur(0, 5, 0, 0);
    press(1'b1, 1'b0);
    @(negedge main_clock);
    model_pulse(1'b0, 1'b1);
    btn_inc = 1'b1;
    repeat (2) @(negedge main_clock);
    btn_inc = 1'b0;
    repeat (2) @(negedge main_clock);
    btn_inc = 1'b1;
    repeat (100) @(negedge main_clock);
    btn_inc = 1'b0;
    repeat (10) @(negedge main_clock);
    @(negedge main_clock);
    btn_inc = 1'b1;
    repeat (3) @(negedge main_clock);
    btn_inc = 1'b0;
    repeat (10) @(negedge main_clock);
    check("bouncy_single_inc", {set_h_msd, set_h_lsd}, {3'd0, 4'd6});

    // Idle timeout in SET_H with blink toggling
    lc0 = load_cycles;
    tick();
    check("blink_on", blank_h, 1'b1);
    tick();
    check("blink_off", blank_h, 1'b0);
    tick();
    check("timeout_pause", pause, 1'b0);
    check("timeout_no_load", load_cycles, lc0);

    // Simultaneous mode + inc in SET_H: mode wins
    set_cur(1, 0, 2, 0);
    press(1'b1, 1'b0);
    tick();
    press(1'b1, 1'b1);
    check("simul_hour_kept", {set_h_msd, set_h_lsd}, {3'd1, 4'd0});
    press(1'b0, 1'b1);
    check("simul_in_set_m", {set_m_msd, set_m_lsd}, {3'd2, 4'd1});
    tick();
    check("blank_m_on", blank_m, 1'b1);

    // Asynchronous reset in the middle of SET_M
    @(negedge main_clock);
    #3;
    main_reset = 1'b0;
    model_reset();
    #1;
    check("async_reset_outputs", dut_view(), model_view(1'b0));
    repeat (3) @(negedge main_clock);
    main_reset = 1'b1;
    repeat (3) @(negedge main_clock);

    // Randomized actions, including illegal captured values
    repeat (80) begin
      set_cur($urandom_range(0, 3), $urandom_range(0, 10),
              $urandom_range(0, 6), $urandom_range(0, 10));
      r = $urandom_range(0, 9);
      if (r <= 2)      press(1'b1, 1'b0);
      else if (r <= 5) press(1'b0, 1'b1);
      else if (r <= 8) tick();
      else             press(1'b1, 1'b1);
    end

    repeat (20) @(negedge main_clock);
    check("queue_drained", exp_q.size(), 0);
    check("load_count", load_cycles, m_loads);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
